// File: rtl/prbs_sync_checker_pkg.sv
// Shared PRBS constants: feedback taps for orders 10..20, checker FSM encoding
// and loss-detect block length. Used by prbs_sync_checker and prbs_predictor.
package prbs_sync_checker_pkg;

    localparam int BLOCK_LEN   = 64;
    localparam int BLOCK_CNT_W = $clog2(BLOCK_LEN);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Bit (t-1) set for each feedback tap t; same polynomials as the PRBS generator.
    function automatic logic [19:0] prbs_taps(input int order);
        case (order)
            10:      return 20'h00240;
            11:      return 20'h00500;
            12:      return 20'h00829;
            13:      return 20'h0100D;
            14:      return 20'h02015;
            15:      return 20'h06000;
            16:      return 20'h0D008;
            17:      return 20'h12000;
            18:      return 20'h20400;
            19:      return 20'h40023;
            20:      return 20'h90000;
            default: return 20'h00000;
        endcase
    endfunction

endpackage

// File: rtl/prbs_predictor.sv
// ORDER-bit Fibonacci LFSR predictor: o_pred is the next expected PRBS bit; the
// register shifts in either the received bit or its own prediction.
module prbs_predictor
    import prbs_sync_checker_pkg::*;
#(
    parameter int ORDER = 14
) (
    input  logic clk,
    input  logic reset,
    input  logic i_shift,
    input  logic i_self,
    input  logic i_data,
    output logic o_pred
);

    localparam logic [19:0]      TAP_FULL = prbs_taps(ORDER);
    localparam logic [ORDER-1:0] TAP_MASK = TAP_FULL[ORDER-1:0];

    logic [ORDER-1:0] r_sr;
    logic [ORDER-1:0] w_terms;

    // r_sr[k] holds the bit seen k+1 shifts ago.
    generate
        for (genvar gi = 0; gi < ORDER; gi++) begin : g_tap
            assign w_terms[gi] = r_sr[gi] & TAP_MASK[gi];
        end
    endgenerate

    assign o_pred = ^w_terms;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr <= '0;
        end else if (i_shift) begin
            r_sr <= {r_sr[ORDER-2:0], (i_self ? o_pred : i_data)};
        end
    end

endmodule

// File: rtl/prbs_sync_checker.sv
// PRBS lock/error checker: SEARCH -> VERIFY -> LOCKED with saturating counters
// and snapshot. Define PRBS_CHK_LOSS_DETECT_EN to enable loss-of-lock per 64-bit block.
module prbs_sync_checker
    import prbs_sync_checker_pkg::*;
#(
    parameter int ORDER       = 14,
    parameter int LOCK_COUNT  = 32,
    parameter int LOSS_THRESH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        data_in,
    input  logic        clear,
    input  logic        snapshot,
    output logic        locked,
    output logic        lock_lost,
    output logic [15:0] error_count,
    output logic [31:0] bit_count,
    output logic        error_flag,
    output logic [15:0] snap_errors,
    output logic [31:0] snap_bits,
    output logic        snap_valid
);

    localparam int FILL_W  = $clog2(ORDER + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int BERR_W  = $clog2(BLOCK_LEN + 1);
`ifdef PRBS_CHK_LOSS_DETECT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    state_t               r_state, w_state_next;
    logic [FILL_W-1:0]    r_fill, w_fill_next;
    logic [MATCH_W-1:0]   r_match, w_match_next;
    logic                 w_pred;
    logic                 w_mismatch;
    logic                 w_in_lock;
    logic                 w_cnt_en;
    logic                 w_lost;
    logic                 r_lock_lost;

    logic [BLOCK_CNT_W-1:0] r_blk_bits;
    logic [BERR_W-1:0]      r_blk_errs;
    logic [BERR_W-1:0]      w_blk_errs_inc;
    logic                   w_blk_trip;

    logic [15:0] r_err_cnt, w_err_next;
    logic [31:0] r_bit_cnt, w_bits_next;
    logic        r_err_flag, w_flag_next;
    logic [15:0] r_snap_err;
    logic [31:0] r_snap_bits;
    logic        r_snap_valid;

    assign w_in_lock  = (r_state == ST_LOCKED);
    assign w_mismatch = data_in ^ w_pred;
    assign w_cnt_en   = enable && w_in_lock;

    prbs_predictor #(
        .ORDER (ORDER)
    ) u_predictor (
        .clk     (clk),
        .reset   (reset),
        .i_shift (enable),
        .i_self  (w_in_lock),
        .i_data  (data_in),
        .o_pred  (w_pred)
    );

    // Errors are tallied per BLOCK_LEN-bit block, aligned to the moment lock was gained.
    assign w_blk_errs_inc = r_blk_errs + BERR_W'(w_mismatch);
    assign w_blk_trip     = LOSS_EN && w_cnt_en && (w_blk_errs_inc >= BERR_W'(LOSS_THRESH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blk_bits <= '0;
            r_blk_errs <= '0;
        end else if (!w_in_lock) begin
            r_blk_bits <= '0;
            r_blk_errs <= '0;
        end else if (enable) begin
            r_blk_bits <= r_blk_bits + BLOCK_CNT_W'(1);
            r_blk_errs <= (r_blk_bits == BLOCK_CNT_W'(BLOCK_LEN - 1)) ? '0 : w_blk_errs_inc;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fill_next  = r_fill;
        w_match_next = r_match;
        w_lost       = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (enable) begin
                    if (r_fill == FILL_W'(ORDER - 1)) begin
                        w_state_next = ST_VERIFY;
                        w_fill_next  = '0;
                        w_match_next = '0;
                    end else begin
                        w_fill_next = r_fill + FILL_W'(1);
                    end
                end
            end
            ST_VERIFY: begin
                if (enable) begin
                    if (w_mismatch) begin
                        w_state_next = ST_SEARCH;
                        w_fill_next  = '0;
                        w_match_next = '0;
                    end else if (r_match == MATCH_W'(LOCK_COUNT - 1)) begin
                        w_state_next = ST_LOCKED;
                        w_match_next = '0;
                    end else begin
                        w_match_next = r_match + MATCH_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (w_blk_trip) begin
                    w_state_next = ST_SEARCH;
                    w_fill_next  = '0;
                    w_lost       = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_SEARCH;
                w_fill_next  = '0;
                w_match_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_SEARCH;
            r_fill      <= '0;
            r_match     <= '0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_fill      <= w_fill_next;
            r_match     <= w_match_next;
            r_lock_lost <= w_lost;
        end
    end

    // clear overrides any increment on the same edge; it is a command, so not gated by enable.
    always_comb begin
        w_err_next  = r_err_cnt;
        w_bits_next = r_bit_cnt;
        if (w_cnt_en && w_mismatch && (r_err_cnt != 16'hFFFF)) begin
            w_err_next = r_err_cnt + 16'd1;
        end
        if (w_cnt_en && (r_bit_cnt != 32'hFFFF_FFFF)) begin
            w_bits_next = r_bit_cnt + 32'd1;
        end
        if (clear) begin
            w_err_next  = '0;
            w_bits_next = '0;
        end
        w_flag_next = !clear && (r_err_flag || (w_err_next == 16'hFFFF));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_err_flag   <= 1'b0;
            r_snap_err   <= '0;
            r_snap_bits  <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            r_err_cnt    <= w_err_next;
            r_bit_cnt    <= w_bits_next;
            r_err_flag   <= w_flag_next;
            r_snap_valid <= snapshot;
            if (snapshot) begin
                r_snap_err  <= r_err_cnt;
                r_snap_bits <= r_bit_cnt;
            end
        end
    end

    assign locked      = w_in_lock;
    assign lock_lost   = r_lock_lost;
    assign error_count = r_err_cnt;
    assign bit_count   = r_bit_cnt;
    assign error_flag  = r_err_flag;
    assign snap_errors = r_snap_err;
    assign snap_bits   = r_snap_bits;
    assign snap_valid  = r_snap_valid;

endmodule

// File: tb/tb_prbs_sync_checker.sv
// Scoreboard bench for prbs_sync_checker (ORDER=14); build with
// PRBS_CHK_LOSS_DETECT_EN defined to exercise loss of lock instead of saturation.
module tb_prbs_sync_checker;

    localparam int ORDER       = 14;
    localparam int LOCK_COUNT  = 32;
    localparam int LOSS_THRESH = 16;
    localparam int BLK         = 64;
`ifdef PRBS_CHK_LOSS_DETECT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, enable, data_in, clear, snapshot;
    logic        locked, lock_lost, error_flag, snap_valid;
    logic [15:0] error_count, snap_errors;
    logic [31:0] bit_count, snap_bits;

    prbs_sync_checker #(
        .ORDER(ORDER), .LOCK_COUNT(LOCK_COUNT), .LOSS_THRESH(LOSS_THRESH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .data_in(data_in),
        .clear(clear), .snapshot(snapshot), .locked(locked), .lock_lost(lock_lost),
        .error_count(error_count), .bit_count(bit_count), .error_flag(error_flag),
        .snap_errors(snap_errors), .snap_bits(snap_bits), .snap_valid(snap_valid)
    );

    always #5 clk = ~clk;

    typedef struct { int unsigned tag; bit lk; bit ll; bit ef; logic [15:0] ec; logic [31:0] bc; } exp_t;
    typedef struct { int unsigned tag; logic [15:0] se; logic [31:0] sb; } snap_t;

    exp_t  q[$];
    snap_t sq[$];
    int unsigned cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int act_lost = 0;
    int taps [4] = '{14, 5, 3, 1};

    // Reference model state
    bit          gh[$];
    bit          seg[$];
    bit          ph[$];
    bit          m_locked, m_flag;
    int unsigned m_err, m_bits;
    int          blk_pos, blk_err, m_lost_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic bit gen_next();
        bit b = 1'b0;
        for (int k = 0; k < 4; k++) b ^= gh[gh.size() - taps[k]];
        gh.push_back(b);
        void'(gh.pop_front());
        return b;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_flag = 0; m_err = 0; m_bits = 0;
        blk_pos = 0; blk_err = 0;
        seg.delete(); ph.delete();
    endtask

    task automatic model_edge(input bit en, input bit d, input bit clr, output bit lost);
        int n;
        bit p;
        lost = 0;
        if (en && !m_locked) begin
            seg.push_back(d);
            n = seg.size();
            if (n > ORDER) begin
                p = 0;
                for (int k = 0; k < 4; k++) p ^= seg[n - 1 - taps[k]];
                if (p != d) begin
                    seg.delete();
                end else if (n == ORDER + LOCK_COUNT) begin
                    m_locked = 1;
                    ph.delete();
                    for (int i = n - ORDER; i < n; i++) ph.push_back(seg[i]);
                    blk_pos = 0; blk_err = 0;
                end
            end
        end else if (en) begin
            p = 0;
            for (int k = 0; k < 4; k++) p ^= ph[ph.size() - taps[k]];
            ph.push_back(p);
            void'(ph.pop_front());
            if (m_bits != 32'hFFFF_FFFF) m_bits++;
            if (p != d && m_err != 32'hFFFF) m_err++;
            if (LOSS_EN) begin
                blk_err += int'(p != d);
                if (blk_err >= LOSS_THRESH) begin
                    m_locked = 0; seg.delete(); lost = 1; m_lost_cnt++;
                end else begin
                    blk_pos++;
                    if (blk_pos == BLK) begin blk_pos = 0; blk_err = 0; end
                end
            end
        end
        if (clr) begin
            m_err = 0; m_bits = 0; m_flag = 0;
        end else if (m_err == 32'hFFFF) begin
            m_flag = 1;
        end
    endtask

    // One clock of stimulus; inv sends the complement of the true PRBS bit.
    task automatic step(input bit en, input bit inv, input bit clr, input bit snp, input bit chk_it);
        bit d, lost;
        @(negedge clk);
        d = en ? (gen_next() ^ inv) : 1'($urandom_range(0, 1));
        enable = en; data_in = d; clear = clr; snapshot = snp;
        if (snp) sq.push_back('{cyc + 1, m_err[15:0], m_bits});
        model_edge(en, d, clr, lost);
        if (chk_it) q.push_back('{cyc + 1, m_locked, lost, m_flag, m_err[15:0], m_bits});
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_lock_lost"}, lock_lost, 0);
        chk({tag, "_error_count"}, error_count, 0);
        chk({tag, "_bit_count"}, bit_count, 0);
        chk({tag, "_error_flag"}, error_flag, 0);
        chk({tag, "_snap_errors"}, snap_errors, 0);
        chk({tag, "_snap_bits"}, snap_bits, 0);
        chk({tag, "_snap_valid"}, snap_valid, 0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2;
        enable = 0; clear = 0; snapshot = 0;
        reset = 1;
        #1;
        check_all_zero("async_reset");
        q.delete(); sq.delete();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    // Monitor: compares DUT outputs against queued expectations for this cycle.
    always @(negedge clk) begin
        exp_t  e;
        snap_t s;
        bit    exp_sv;
        if (lock_lost === 1'b1) act_lost++;
        exp_sv = (sq.size() > 0 && sq[0].tag == cyc);
        chk("snap_valid", snap_valid, exp_sv);
        if (exp_sv) begin
            s = sq.pop_front();
            chk("snap_errors", snap_errors, s.se);
            chk("snap_bits", snap_bits, s.sb);
        end
        while (q.size() > 0 && q[0].tag <= cyc) begin
            e = q.pop_front();
            if (e.tag != cyc) begin
                chk("exp_stale", e.tag, cyc);
            end else begin
                chk("locked", locked, e.lk);
                chk("lock_lost", lock_lost, e.ll);
                chk("error_flag", error_flag, e.ef);
                chk("error_count", error_count, e.ec);
                chk("bit_count", bit_count, e.bc);
            end
        end
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned seedbits;
        int g;
        logic [15:0] held_err;
        reset = 1; enable = 0; data_in = 0; clear = 0; snapshot = 0;
        seedbits = $urandom() | 32'h1;
        for (int i = 0; i < ORDER; i++) gh.push_back(seedbits[i]);
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 0;

        // Clean stream: lock on the 46th enabled sample.
        for (int i = 0; i < ORDER + LOCK_COUNT - 1; i++) step(1, 0, 0, 0, 1);
        settle();
        chk("locked_at_45", locked, 0);
        step(1, 0, 0, 0, 1);
        settle();
        chk("locked_at_46", locked, 1);
        chk("err_after_lock", error_count, 0);

        // Randomised locked traffic: enable gaps, sparse errors, snapshots, clears.
        for (int i = 0; i < 300; i++) begin
            bit en;
            en = ($urandom_range(0, 9) != 0);
            step(en, en && ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 15) == 0), 1);
        end

        // Single line error counts exactly once.
        step(1, 0, 1, 0, 1);
        step(1, 1, 0, 0, 1);
        settle();
        chk("single_err_count", error_count, 1);
        chk("single_err_locked", locked, 1);

        // snapshot + clear on the same edge with error_count = 5.
        repeat (4) step(1, 1, 0, 0, 1);
        step(1, 0, 1, 1, 1);
        settle();
        chk("snapclr_err", error_count, 0);
        chk("snapclr_valid", snap_valid, 1);
        chk("snapclr_snap", snap_errors, 5);

        mid_reset();

        // Mismatch on the 31st VERIFY comparison falls back to SEARCH.
        for (int i = 0; i < ORDER + LOCK_COUNT - 2; i++) step(1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 1);
        settle();
        chk("verify_miss_locked", locked, 0);
        for (int i = 0; i < ORDER + LOCK_COUNT - 3; i++) step(1, 0, 0, 0, 1);
        settle();
        chk("relock_at_45", locked, 0);
        step(1, 0, 0, 0, 1);
        settle();
        chk("relock_at_46", locked, 1);

`ifdef PRBS_CHK_LOSS_DETECT_EN
        repeat (5) step(1, 0, 0, 0, 1);
        repeat (LOSS_THRESH) step(1, 1, 0, 0, 1);
        settle();
        chk("loss_locked", locked, 0);
        chk("loss_pulse", lock_lost, 1);
        held_err = error_count;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
        settle();
        chk("loss_err_hold", error_count, held_err);
        for (int i = 0; i < ORDER + LOCK_COUNT - 4; i++) step(1, 0, 0, 0, 1);
        settle();
        chk("loss_relock_45", locked, 0);
        step(1, 0, 0, 0, 1);
        settle();
        chk("loss_relock_46", locked, 1);
`else
        // Drive error_count to 16'hFFFE with a fully inverted stream, then saturate.
        held_err = 16'hFFFE;
        step(1, 0, 1, 0, 1);
        g = 0;
        while (m_err < 32'hFFFE && g < 70000) begin
            step(1, 1, 0, 0, 0);
            g++;
        end
        settle();
        chk("sat_preload", error_count, held_err);
        chk("sat_pre_flag", error_flag, 0);
        repeat (3) step(1, 1, 0, 0, 1);
        settle();
        chk("sat_count", error_count, 16'hFFFF);
        chk("sat_flag", error_flag, 1);
        chk("sat_locked", locked, 1);
        step(1, 0, 1, 0, 1);
        settle();
        chk("sat_clear_count", error_count, 0);
        chk("sat_clear_flag", error_flag, 0);
`endif

        repeat (4) step(0, 0, 0, 0, 1);
        repeat (3) @(negedge clk);
        chk("lock_lost_pulses", act_lost, m_lost_cnt);
        chk("snap_pending", sq.size(), 0);
        chk("exp_pending", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
